// File: rtl/tour_cmd_if.sv
// Handshake bundle between the tour replay block, the knight's-tour solver,
// the UART wrapper and the command processor.
interface tour_cmd_if;
    // solver side
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    // UART wrapper side
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    // command processor side
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tour_err;

    // environment view: drives the solver, UART and command processor inputs
    modport master (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, tour_err
    );

    // tour_cmd view
    modport slave (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp, tour_err
    );
endinterface

// File: rtl/tour_cmd.sv
// Tour replay: walks the 24 solved knight moves, turning each one-hot move
// into a vertical leg and a horizontal leg-with-fanfare for the command
// processor. While idle, UART commands pass straight through.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no tour; UART pass-through, waiting for start_tour
// VERT   | vertical leg presented (cmd_rdy=1), waiting for clr_cmd_rdy
// WAIT_V | vertical leg latched, waiting for send_resp
// HORZ   | horizontal leg presented (cmd_rdy=1), waiting for clr_cmd_rdy
// WAIT_H | horizontal leg latched, waiting for send_resp; then next move
module tour_cmd (
    input logic     clk,
    input logic     rst_n,
    tour_cmd_if.slave bus
);

    localparam logic [3:0] OP_MOVE  = 4'h2;
    localparam logic [3:0] OP_FANF  = 4'h3;
    localparam logic [7:0] HD_N     = 8'h00;
    localparam logic [7:0] HD_W     = 8'h3F;
    localparam logic [7:0] HD_S     = 8'h7F;
    localparam logic [7:0] HD_E     = 8'hBF;
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;
    localparam logic [4:0] LAST_IDX  = 5'd23;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [4:0]  mv_indx, mv_indx_nxt;
    logic        tour_err, tour_err_nxt;

    logic        move_ok;
    logic [15:0] cmd_vert;
    logic [15:0] cmd_horz;

    logic [15:0] cmd_o;
    logic        cmd_rdy_o;
    logic        clr_uart_o;
    logic [7:0]  resp_o;

    // Decode the solver's one-hot move into the two legs; anything that is
    // not exactly one bit set is flagged as a corrupt tour.
    always_comb begin
        move_ok  = 1'b1;
        cmd_vert = 16'h0000;
        cmd_horz = 16'h0000;
        case (bus.move)
            8'h01: begin cmd_vert = {OP_MOVE, HD_N, 4'd2}; cmd_horz = {OP_FANF, HD_W, 4'd1}; end
            8'h02: begin cmd_vert = {OP_MOVE, HD_N, 4'd2}; cmd_horz = {OP_FANF, HD_E, 4'd1}; end
            8'h04: begin cmd_vert = {OP_MOVE, HD_N, 4'd1}; cmd_horz = {OP_FANF, HD_W, 4'd2}; end
            8'h08: begin cmd_vert = {OP_MOVE, HD_S, 4'd1}; cmd_horz = {OP_FANF, HD_W, 4'd2}; end
            8'h10: begin cmd_vert = {OP_MOVE, HD_S, 4'd2}; cmd_horz = {OP_FANF, HD_W, 4'd1}; end
            8'h20: begin cmd_vert = {OP_MOVE, HD_S, 4'd2}; cmd_horz = {OP_FANF, HD_E, 4'd1}; end
            8'h40: begin cmd_vert = {OP_MOVE, HD_S, 4'd1}; cmd_horz = {OP_FANF, HD_E, 4'd2}; end
            8'h80: begin cmd_vert = {OP_MOVE, HD_N, 4'd1}; cmd_horz = {OP_FANF, HD_E, 4'd2}; end
            default: move_ok = 1'b0;
        endcase
    end

    // State, move index and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mv_indx  <= 5'd0;
            tour_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            mv_indx  <= mv_indx_nxt;
            tour_err <= tour_err_nxt;
        end
    end

    // Next-state logic and handshake outputs; IDLE is a transparent UART path.
    always_comb begin
        state_nxt    = state;
        mv_indx_nxt  = mv_indx;
        tour_err_nxt = 1'b0;
        cmd_o        = 16'h0000;
        cmd_rdy_o    = 1'b0;
        clr_uart_o   = 1'b0;
        resp_o       = RESP_BUSY;

        case (state)
            IDLE: begin
                cmd_o      = bus.cmd_UART;
                cmd_rdy_o  = bus.cmd_rdy_UART;
                clr_uart_o = bus.clr_cmd_rdy;
                resp_o     = RESP_DONE;
                if (bus.start_tour) begin
                    state_nxt   = VERT;
                    mv_indx_nxt = 5'd0;
                end
            end
            VERT: begin
                if (!move_ok) begin
                    tour_err_nxt = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    cmd_o     = cmd_vert;
                    cmd_rdy_o = 1'b1;
                    if (bus.clr_cmd_rdy)
                        state_nxt = WAIT_V;
                end
            end
            WAIT_V: begin
                cmd_o = cmd_vert;
                if (bus.send_resp)
                    state_nxt = HORZ;
            end
            HORZ: begin
                cmd_o     = cmd_horz;
                cmd_rdy_o = 1'b1;
                if (bus.clr_cmd_rdy)
                    state_nxt = WAIT_H;
            end
            WAIT_H: begin
                cmd_o = cmd_horz;
                // the last acknowledge of the tour reads "done" to the host
                if (mv_indx == LAST_IDX)
                    resp_o = RESP_DONE;
                if (bus.send_resp) begin
                    if (mv_indx == LAST_IDX) begin
                        state_nxt   = IDLE;
                        mv_indx_nxt = 5'd0;
                    end else begin
                        state_nxt   = VERT;
                        mv_indx_nxt = mv_indx + 5'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mv_indx          = mv_indx;
    assign bus.tour_err         = tour_err;
    assign bus.cmd              = cmd_o;
    assign bus.cmd_rdy          = cmd_rdy_o;
    assign bus.clr_cmd_rdy_UART = clr_uart_o;
    assign bus.resp             = resp_o;

endmodule

// File: tb/tb_tour_cmd.sv
// Bench for tour_cmd: a behavioural solver memory feeds moves, a reference
// derived from the (dx,dy) knight table predicts every command, and the
// command-processor handshake is served with random latencies and noise.
module tb_tour_cmd;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tour_cmd_if bus ();

    tour_cmd dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] tour [0:31];
    assign bus.move = tour[bus.mv_indx];

    int checks = 0;
    int errors = 0;
    bit noise_start = 1'b0;

    int dx_tab [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    int dy_tab [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

    function automatic logic [15:0] ref_cmd(input logic [7:0] mv, input bit horiz);
        int d;
        logic [7:0] hd;
        logic [3:0] mag;
        d = 0;
        for (int b = 0; b < 8; b++)
            if (mv[b]) d = horiz ? dx_tab[b] : dy_tab[b];
        mag = 4'(d < 0 ? -d : d);
        if (horiz) hd = (d > 0) ? 8'hBF : 8'h3F;
        else       hd = (d > 0) ? 8'h00 : 8'h7F;
        return {(horiz ? 4'h3 : 4'h2), hd, mag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
    endtask

    task automatic make_tour();
        logic [7:0] tmp;
        int j;
        for (int b = 0; b < 8; b++) tour[b] = 8'(1 << b);
        for (int i = 7; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = tour[i]; tour[i] = tour[j]; tour[j] = tmp;
        end
        for (int i = 8; i < 24; i++) tour[i] = 8'(1 << $urandom_range(0, 7));
        for (int i = 24; i < 32; i++) tour[i] = 8'h00;
    endtask

    // Serve one leg: check presentation, random hold, clr, random wait, send_resp.
    task automatic serve_leg(input logic [15:0] exp, input logic [7:0] exp_resp, input logic [4:0] idx);
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp) begin
            errors++;
            $display("FAIL leg_present idx=%0d got rdy=%b cmd=%h need rdy=1 cmd=%h", idx, bus.cmd_rdy, bus.cmd, exp);
        end
        checks++;
        if (bus.mv_indx !== idx || bus.clr_cmd_rdy_UART !== 1'b0 || bus.tour_err !== 1'b0 || bus.resp !== 8'h5A) begin
            errors++;
            $display("FAIL leg_status got idx=%0d clrU=%b err=%b resp=%h need idx=%0d clrU=0 err=0 resp=5a",
                     bus.mv_indx, bus.clr_cmd_rdy_UART, bus.tour_err, bus.resp, idx);
        end
        repeat ($urandom_range(0, 2)) begin
            bus.send_resp  = 1'($urandom_range(0, 1));
            bus.start_tour = noise_start ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            checks++;
            if (bus.cmd_rdy !== 1'b1 || bus.cmd !== exp || bus.mv_indx !== idx) begin
                errors++;
                $display("FAIL leg_hold idx=%0d got rdy=%b cmd=%h mv=%0d need rdy=1 cmd=%h", idx, bus.cmd_rdy, bus.cmd, bus.mv_indx, exp);
            end
        end
        bus.send_resp   = 1'b0;
        bus.start_tour  = 1'b0;
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        checks++;
        if (bus.cmd_rdy !== 1'b0 || bus.cmd !== exp) begin
            errors++;
            $display("FAIL leg_cleared idx=%0d got rdy=%b cmd=%h need rdy=0 cmd=%h", idx, bus.cmd_rdy, bus.cmd, exp);
        end
        repeat ($urandom_range(0, 2)) begin
            bus.clr_cmd_rdy = 1'($urandom_range(0, 1));
            bus.start_tour  = noise_start ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            checks++;
            if (bus.cmd_rdy !== 1'b0 || bus.mv_indx !== idx || bus.clr_cmd_rdy_UART !== 1'b0) begin
                errors++;
                $display("FAIL leg_wait idx=%0d got rdy=%b mv=%0d clrU=%b need rdy=0 mv=%0d clrU=0",
                         idx, bus.cmd_rdy, bus.mv_indx, bus.clr_cmd_rdy_UART, idx);
            end
        end
        bus.clr_cmd_rdy = 1'b0;
        bus.start_tour  = 1'b0;
        bus.send_resp   = 1'b1;
        #1;
        checks++;
        if (bus.resp !== exp_resp) begin
            errors++;
            $display("FAIL leg_resp idx=%0d got %h need %h", idx, bus.resp, exp_resp);
        end
        tick();
        bus.send_resp = 1'b0;
    endtask

    task automatic play_tour(input int stop);
        for (int i = 0; i < stop; i++) begin
            serve_leg(ref_cmd(tour[i], 1'b0), 8'h5A, 5'(i));
            serve_leg(ref_cmd(tour[i], 1'b1), (i == 23) ? 8'hA5 : 8'h5A, 5'(i));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_tour = 1'b0; bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
        bus.cmd_UART = 16'h2003; bus.cmd_rdy_UART = 1'b1;
        make_tour();
        tick(); tick();
        checks++;
        if (bus.mv_indx !== 5'd0 || bus.tour_err !== 1'b0 || bus.cmd !== 16'h2003 || bus.cmd_rdy !== 1'b1 || bus.resp !== 8'hA5) begin
            errors++;
            $display("FAIL reset_vals got mv=%0d err=%b cmd=%h rdy=%b resp=%h need 0 0 2003 1 a5",
                     bus.mv_indx, bus.tour_err, bus.cmd, bus.cmd_rdy, bus.resp);
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.cmd_UART     = (k == 0) ? 16'h2003 : 16'($urandom);
            bus.cmd_rdy_UART = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.clr_cmd_rdy  = 1'(k % 2);
            #1;
            checks++;
            if (bus.cmd !== bus.cmd_UART || bus.cmd_rdy !== bus.cmd_rdy_UART ||
                bus.clr_cmd_rdy_UART !== bus.clr_cmd_rdy || bus.resp !== 8'hA5) begin
                errors++;
                $display("FAIL passthru k=%0d got cmd=%h rdy=%b clrU=%b resp=%h", k, bus.cmd, bus.cmd_rdy, bus.clr_cmd_rdy_UART, bus.resp);
            end
            tick();
        end
        bus.clr_cmd_rdy = 1'b0;
        bus.cmd_rdy_UART = 1'b0;
    endtask

    task automatic test_single_move();
        make_tour();
        tour[0] = 8'h01;
        start_pulse();
        checks++;
        if (bus.cmd !== 16'h2002 || bus.cmd_rdy !== 1'b1 || bus.mv_indx !== 5'd0) begin
            errors++;
            $display("FAIL single_vert got cmd=%h rdy=%b mv=%0d need 2002 1 0", bus.cmd, bus.cmd_rdy, bus.mv_indx);
        end
        bus.clr_cmd_rdy = 1'b1; tick(); bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b1; tick(); bus.send_resp = 1'b0;
        checks++;
        if (bus.cmd !== 16'h33F1 || bus.cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL single_horz got cmd=%h rdy=%b need 33f1 1", bus.cmd, bus.cmd_rdy);
        end
        bus.clr_cmd_rdy = 1'b1; tick(); bus.clr_cmd_rdy = 1'b0;
        checks++;
        if (bus.resp !== 8'h5A || bus.cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL single_resp got resp=%h rdy=%b need 5a 0", bus.resp, bus.cmd_rdy);
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_full_tour(input bit with_noise);
        logic [15:0] pend;
        make_tour();
        pend = 16'($urandom);
        bus.cmd_UART = pend;
        bus.cmd_rdy_UART = 1'b1;
        noise_start = with_noise;
        start_pulse();
        play_tour(24);
        noise_start = 1'b0;
        checks++;
        if (bus.mv_indx !== 5'd0 || bus.cmd !== pend || bus.cmd_rdy !== 1'b1 || bus.resp !== 8'hA5) begin
            errors++;
            $display("FAIL tour_end got mv=%0d cmd=%h rdy=%b resp=%h need 0 %h 1 a5", bus.mv_indx, bus.cmd, bus.cmd_rdy, bus.resp, pend);
        end
        bus.clr_cmd_rdy = 1'b1;
        #1;
        checks++;
        if (bus.clr_cmd_rdy_UART !== 1'b1) begin
            errors++;
            $display("FAIL tour_end_clr got %b need 1", bus.clr_cmd_rdy_UART);
        end
        tick();
        bus.clr_cmd_rdy = 1'b0;
        bus.cmd_rdy_UART = 1'b0;
        tick();
        checks++;
        if (bus.cmd_rdy !== 1'b0 || bus.mv_indx !== 5'd0) begin
            errors++;
            $display("FAIL tour_idle got rdy=%b mv=%0d need 0 0", bus.cmd_rdy, bus.mv_indx);
        end
    endtask

    task automatic test_tour_err();
        make_tour();
        tour[5] = 8'h03;
        bus.cmd_UART = 16'h1234;
        bus.cmd_rdy_UART = 1'b1;
        start_pulse();
        play_tour(5);
        checks++;
        if (bus.mv_indx !== 5'd5 || bus.cmd_rdy !== 1'b0 || bus.tour_err !== 1'b0) begin
            errors++;
            $display("FAIL err_detect got mv=%0d rdy=%b err=%b need 5 0 0", bus.mv_indx, bus.cmd_rdy, bus.tour_err);
        end
        tick();
        checks++;
        if (bus.tour_err !== 1'b1 || bus.cmd !== 16'h1234 || bus.cmd_rdy !== 1'b1 || bus.resp !== 8'hA5) begin
            errors++;
            $display("FAIL err_pulse got err=%b cmd=%h rdy=%b resp=%h need 1 1234 1 a5", bus.tour_err, bus.cmd, bus.cmd_rdy, bus.resp);
        end
        tick();
        checks++;
        if (bus.tour_err !== 1'b0 || bus.cmd !== 16'h1234) begin
            errors++;
            $display("FAIL err_oneshot got err=%b cmd=%h need 0 1234", bus.tour_err, bus.cmd);
        end
        bus.cmd_rdy_UART = 1'b0;
        tour[5] = 8'h40;
        start_pulse();
        checks++;
        if (bus.mv_indx !== 5'd0 || bus.cmd !== ref_cmd(tour[0], 1'b0) || bus.cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL err_restart got mv=%0d cmd=%h rdy=%b need 0 %h 1", bus.mv_indx, bus.cmd, bus.cmd_rdy, ref_cmd(tour[0], 1'b0));
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_reset_mid();
        make_tour();
        bus.cmd_UART = 16'hBEEF;
        bus.cmd_rdy_UART = 1'b0;
        start_pulse();
        play_tour(10);
        serve_leg(ref_cmd(tour[10], 1'b0), 8'h5A, 5'd10);
        checks++;
        if (bus.cmd !== ref_cmd(tour[10], 1'b1) || bus.cmd_rdy !== 1'b1 || bus.mv_indx !== 5'd10) begin
            errors++;
            $display("FAIL mid_horz got cmd=%h rdy=%b mv=%0d", bus.cmd, bus.cmd_rdy, bus.mv_indx);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mv_indx !== 5'd0 || bus.cmd !== 16'hBEEF || bus.cmd_rdy !== 1'b0 || bus.resp !== 8'hA5 || bus.tour_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got mv=%0d cmd=%h rdy=%b resp=%h err=%b", bus.mv_indx, bus.cmd, bus.cmd_rdy, bus.resp, bus.tour_err);
        end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (bus.mv_indx !== 5'd0 || bus.cmd !== 16'hBEEF || bus.cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL mid_noresume got mv=%0d cmd=%h rdy=%b", bus.mv_indx, bus.cmd, bus.cmd_rdy);
        end
        start_pulse();
        play_tour(24);
        checks++;
        if (bus.mv_indx !== 5'd0 || bus.resp !== 8'hA5 || bus.cmd !== 16'hBEEF) begin
            errors++;
            $display("FAIL mid_rerun got mv=%0d resp=%h cmd=%h", bus.mv_indx, bus.resp, bus.cmd);
        end
    endtask

    task automatic test_same_cycle();
        make_tour();
        start_pulse();
        bus.clr_cmd_rdy = 1'b1; bus.send_resp = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
        tick(); tick();
        checks++;
        if (bus.cmd_rdy !== 1'b0 || bus.cmd !== ref_cmd(tour[0], 1'b0)) begin
            errors++;
            $display("FAIL same_v got rdy=%b cmd=%h need 0 %h", bus.cmd_rdy, bus.cmd, ref_cmd(tour[0], 1'b0));
        end
        bus.send_resp = 1'b1; tick(); bus.send_resp = 1'b0;
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.cmd !== ref_cmd(tour[0], 1'b1)) begin
            errors++;
            $display("FAIL same_horz got rdy=%b cmd=%h need 1 %h", bus.cmd_rdy, bus.cmd, ref_cmd(tour[0], 1'b1));
        end
        bus.clr_cmd_rdy = 1'b1; bus.send_resp = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
        tick();
        checks++;
        if (bus.cmd_rdy !== 1'b0 || bus.mv_indx !== 5'd0) begin
            errors++;
            $display("FAIL same_h got rdy=%b mv=%0d need 0 0", bus.cmd_rdy, bus.mv_indx);
        end
        bus.send_resp = 1'b1; tick(); bus.send_resp = 1'b0;
        checks++;
        if (bus.mv_indx !== 5'd1 || bus.cmd_rdy !== 1'b1 || bus.cmd !== ref_cmd(tour[1], 1'b0)) begin
            errors++;
            $display("FAIL same_next got mv=%0d rdy=%b cmd=%h need 1 1 %h", bus.mv_indx, bus.cmd_rdy, bus.cmd, ref_cmd(tour[1], 1'b0));
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_tour = 1'b0; bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
        bus.cmd_UART = 16'h0000; bus.cmd_rdy_UART = 1'b0;
        test_reset();
        test_single_move();
        test_full_tour(1'b0);
        test_full_tour(1'b1);
        test_tour_err();
        test_reset_mid();
        test_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tour_cmd.md
# tour_cmd

Downstream consumer of the knight's-tour solver. Walks the 24 solved moves by driving the solver's move index and decodes each one-hot move into two motion commands: a vertical leg, then a horizontal leg with fanfare. Each command goes to the command processor through a ready/clear/response handshake. When no tour is running, the block passes UART commands straight through to the command processor.

## Interface
- No parameters.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start_tour  in  1  one-cycle pulse (solver done); starts tour replay
- move  in  8  one-hot move read from solver at mv_indx (combinational from solver)
- mv_indx  out  5  index of move being replayed, 0..23
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  acknowledge to UART wrapper
- cmd  out  16  command to command processor
- cmd_rdy  out  1  cmd valid
- clr_cmd_rdy  in  1  command processor has latched cmd
- send_resp  in  1  command processor finished executing cmd
- resp  out  8  response byte to UART
- tour_err  out  1  one-cycle pulse: non-one-hot move, tour aborted

## Operation
- Command format: cmd[15:12] opcode, cmd[11:4] heading, cmd[3:0] squares. Opcode 4'h2 = move, 4'h3 = move with fanfare. Headings: N 8'h00, W 8'h3F, S 8'h7F, E 8'hBF.
- Move decode, as (dx,dy):
  - bit0 (-1,+2); bit1 (+1,+2); bit2 (-2,+1); bit3 (-2,-1)
  - bit4 (-1,-2); bit5 (+1,-2); bit6 (+2,-1); bit7 (+2,+1)
  - +y = N, -y = S, +x = E, -x = W.
- Vertical command: {4'h2, N/S, |dy|}. Horizontal command: {4'h3, E/W, |dx|}.
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5. start_tour -> VERT, mv_indx<=0.
  - VERT: if move is not one-hot (includes 8'h00), pulse tour_err and go to IDLE. Otherwise cmd=vertical, cmd_rdy=1; on clr_cmd_rdy -> WAIT_V.
  - WAIT_V: cmd_rdy=0, cmd holds vertical. send_resp -> HORZ.
  - HORZ: cmd=horizontal, cmd_rdy=1; on clr_cmd_rdy -> WAIT_H.
  - WAIT_H: cmd_rdy=0. On send_resp:
    - mv_indx==23: go to IDLE, mv_indx<=0.
    - otherwise: mv_indx<=mv_indx+1, go to VERT.
- resp outside IDLE: 8'h5A. Exception: in WAIT_H with mv_indx==23, resp=8'hA5 so the final acknowledge reads "done".
- Outside IDLE: cmd_rdy_UART is ignored and clr_cmd_rdy_UART=0. UART commands stay pending until the tour ends.
- start_tour outside IDLE is ignored.
- send_resp in VERT/HORZ and clr_cmd_rdy in WAIT_V/WAIT_H are ignored.
- mv_indx is a registered 5-bit counter; it never exceeds 23 and changes only as stated above.

## Timing
- Reset values: state IDLE, mv_indx 0, tour_err 0. cmd, cmd_rdy and clr_cmd_rdy_UART follow the IDLE pass-through; resp=8'hA5.
- cmd, cmd_rdy, resp and clr_cmd_rdy_UART are combinational from state, mv_indx, move and the pass-through inputs. tour_err is registered.
- start_tour sampled at edge N: mv_indx=0 and cmd_rdy=1 with the vertical command from edge N+1.
- move must be valid in the same cycle as mv_indx; the solver read is combinational.
- clr_cmd_rdy at edge N: cmd_rdy=0 from N+1.
- send_resp at edge N in WAIT_V: cmd_rdy=1 with the horizontal command from N+1.
- send_resp at edge N in WAIT_H: the next mv_indx and vertical command are presented from N+1.
- Minimum per move with same-cycle responses: 4 cycles.
- clr_cmd_rdy and send_resp arriving in the same cycle in VERT: only clr is taken; send_resp must recur in WAIT_V.
- rst_n asserted mid-tour: immediate return to reset values; the tour is not resumed.

## Test plan
- Reset, no tour: cmd_UART=16'h2003 with cmd_rdy_UART=1 -> cmd=16'h2003, cmd_rdy=1, clr_cmd_rdy_UART mirrors clr_cmd_rdy, resp=8'hA5.
- start_tour, move[0]=8'h01 (bit0) -> cmd=16'h2002 (N,2) with cmd_rdy=1. After clr and send_resp -> cmd=16'h3BF1... for bit0 the horizontal leg is W,1, so cmd=16'h33F1. resp=8'h5A after the horizontal acknowledge.
- Full 24-move replay of a known tour, one bit per move covering all 8 encodings -> 48 commands matching the decode table. mv_indx runs 0..23. resp=8'hA5 only on the final send_resp, then the block returns to IDLE pass-through.
- move=8'h03 at mv_indx=5 -> tour_err pulses one cycle, state returns to IDLE, no command issued for index 5.
- cmd_rdy_UART=1 and a second start_tour during the tour -> both ignored, clr_cmd_rdy_UART=0. The UART command passes through once the tour completes.
- rst_n low while in HORZ at mv_indx=10 -> next cycle mv_indx=0 and pass-through restored; a new start_tour restarts from index 0.
